debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Multi-channel synchronise-and-debounce bank for board buttons/switches.
//  Filters both press and release edges.
//  Provides a debounced level plus single-cycle rise/fall pulses per channel.
//  Sits between top-level pins and user FSMs, replacing per-pin debouncers.
// PARAMETERS
//  CHANNELS      4   number of independent input channels (>=1)
//  DELAY_CYCLES  10  consecutive disagreeing cycles required to accept a change (>=1)
//  SYNC_STAGES   2   flip-flops in each input synchroniser (>=2)
//  ACTIVE_LOW    0   1: raw pins are active-low; inverted before synchronising
// PORTS
//  clk      in   1         system clock; all state on posedge
//  rst_n    in   1         asynchronous, active-low reset
//  bouncy   in   CHANNELS  raw asynchronous pin levels
//  stable   out  CHANNELS  debounced logical level (1 = asserted)
//  rise     out  CHANNELS  1-cycle pulse when stable[i] goes 0->1
//  fall     out  CHANNELS  1-cycle pulse when stable[i] goes 1->0
//  any_edge out  1         OR of all rise|fall bits, same cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync chains, stable, cnt, rise, fall, any_edge all 0.
//  - Logical input: in[i] = bouncy[i] ^ ACTIVE_LOW. This feeds a SYNC_STAGES-deep chain.
//    s[i] is the last chain stage.
//  - Per-channel counter cnt[i], width max(1,$clog2(DELAY_CYCLES)), range 0..DELAY_CYCLES-1.
//  - Each posedge:
//    s==stable          -> cnt<=0
//    s!=stable, cnt<D-1 -> cnt<=cnt+1
//    s!=stable, cnt==D-1 -> stable<=s, cnt<=0, rise/fall<=1 per direction
//  - rise/fall are registered and high for exactly one cycle, coincident with the stable change.
//    rise&fall is never 1 on one channel.
//  - Latency: input changed before edge k (and held) makes stable change visible after
//    edge k+SYNC_STAGES+DELAY_CYCLES-1. Defaults: 11 edges.
//  - Glitch rejection: a mismatch lasting < DELAY_CYCLES synced cycles clears cnt.
//    stable and pulses are untouched. Counting restarts from 0 on the next mismatch.
//  - Filtering is symmetric: release is debounced exactly like press.
//  - DELAY_CYCLES=1: stable follows s with one register of delay; no filtering.
//  - Channels are fully independent. Simultaneous edges on several channels each pulse;
//    any_edge is a single 1.
//  - Reset mid-count: cnt and stable clear immediately; no pulse is emitted on reset
//    or on its release.
//  - After reset, a channel whose pin is already asserted rises after the normal latency.
//    rise pulses once.
// STRUCTURE
//  - Package debounce_pkg:
//    localparam function cnt_width(delay) = max(1,$clog2(delay)).
//    Default constants DEBOUNCE_DELAY_DEFAULT=10 and SYNC_STAGES_DEFAULT=2.
//  - Sub-module debounce_channel: one sync chain, counter, stable and pulse registers.
//    Instantiated CHANNELS times in a generate loop.
//  - The top level computes any_edge as a combinational OR of the registered pulses
//    only; no other logic.
// TESTING (CHANNELS=4, DELAY_CYCLES=10, SYNC_STAGES=2, ACTIVE_LOW=0)
//  1 Clean press: bouncy[0] 0->1 before edge k, held.
//    -> stable[0]=1 and rise[0]=1 after edge k+11; rise[0]=0 after edge k+12.
//    Other channels stay 0.
//  2 Bounce: bouncy[1] toggles 1,0,1,0 for 3 cycles each, then held 1.
//    -> exactly one rise[1], 11 edges after the final 0->1 (the last low phase is
//    already synchronised); no fall[1].
//  3 Glitch: bouncy[2]=1 for 9 cycles, then 0.
//    -> stable[2], rise[2] and any_edge never assert.
//  4 Release: channel 0 stable=1, bouncy[0] 1->0 held.
//    -> fall[0] 1-cycle pulse after 11 edges; stable[0]=0.
//  5 Simultaneous: bouncy[3:0] 0000->1111 on the same cycle.
//    -> rise=1111 in one cycle; any_edge high for exactly that cycle.
//  6 Reset mid-count: assert rst_n=0 at count 5 on channel 0 with stable=0.
//    -> all outputs 0 asynchronously. Release with pin still 1 -> single rise[0]
//    11 edges after the first post-reset edge.
//    Repeat with ACTIVE_LOW=1 and inverted stimulus: identical stable/rise/fall.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and sizing helper for the debounce bank and its per-channel filter.
// Pure compile-time content; no logic, no latency.
package debounce_pkg;

   localparam int DEBOUNCE_DELAY_DEFAULT = 10;
   localparam int SYNC_STAGES_DEFAULT    = 2;

   // Counter width that can hold 0..delay-1; never narrower than one bit.
   function automatic int cnt_width(input int delay);
      int w;
      w = $clog2(delay);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: input synchroniser, disagreement counter, debounced level and edge pulses.
// Latency SYNC_STAGES+DELAY_CYCLES-1 edges from a held pin change to stable; no backpressure.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DELAY_CYCLES = DEBOUNCE_DELAY_DEFAULT,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bouncy,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int            CW       = cnt_width(DELAY_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;
   logic                   mismatch;
   logic                   expire;

   // Polarity is normalised before the first flop so everything downstream is active-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bouncy ^ ACTIVE_LOW};
      end
   end

   assign s        = sync[SYNC_STAGES-1];
   assign mismatch = s ^ stable;
   assign expire   = mismatch && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= expire && s;
         fall <= expire && !s;
         if (!mismatch) begin
            cnt <= '0;
         end else if (expire) begin
            cnt    <= '0;
            stable <= s;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Direction is taken from s at the moment of acceptance, so both pulses cannot coincide.
   a_pulse_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(rise && fall));

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced channels with a shared any-edge flag.
// Latency SYNC_STAGES+DELAY_CYCLES-1 edges per channel; any_edge is same-cycle; no backpressure.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int DELAY_CYCLES = DEBOUNCE_DELAY_DEFAULT,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] bouncy,
   output logic [CHANNELS-1:0] stable,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_edge
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .DELAY_CYCLES (DELAY_CYCLES),
         .SYNC_STAGES  (SYNC_STAGES),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .bouncy (bouncy[i]),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   // Built only from registered pulses, so it is glitch-free within the cycle.
   assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: active-high and active-low instances driven with mirrored pins.
module tb_debounce_bank;
   import debounce_pkg::*;

   localparam int CH = 4;
   localparam int D  = 10;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] pins;
   logic [CH-1:0] pins_n;
   logic [CH-1:0] stable_h, rise_h, fall_h;
   logic [CH-1:0] stable_l, rise_l, fall_l;
   logic          any_h, any_l;

   assign pins_n = ~pins;

   always #5 clk = ~clk;

   debounce_bank #(.CHANNELS(CH), .DELAY_CYCLES(D), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst_n(rst_n), .bouncy(pins),
      .stable(stable_h), .rise(rise_h), .fall(fall_h), .any_edge(any_h));

   debounce_bank #(.CHANNELS(CH), .DELAY_CYCLES(D), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst_n(rst_n), .bouncy(pins_n),
      .stable(stable_l), .rise(rise_l), .fall(fall_l), .any_edge(any_l));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a level is accepted once the synchronised input has disagreed
   // with the current level on each of the last D edges, all since the previous change.
   logic          inq [CH][$];
   logic          sq  [CH][$];
   int            since [CH];
   logic [CH-1:0] m_stable, m_rise, m_fall;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         inq[c] = {};
         repeat (SS) inq[c].push_back(1'b0);
         sq[c]    = {};
         since[c] = 0;
      end
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
   endtask

   task automatic model_edge();
      logic s;
      logic all_dis;
      for (int c = 0; c < CH; c++) begin
         inq[c].push_back(pins[c]);
         s = inq[c].pop_front();
         sq[c].push_back(s);
         if (sq[c].size() > D) void'(sq[c].pop_front());
         since[c]++;
         m_rise[c] = 1'b0;
         m_fall[c] = 1'b0;
         all_dis = (sq[c].size() == D);
         foreach (sq[c][j]) if (sq[c][j] == m_stable[c]) all_dis = 1'b0;
         if (since[c] >= D && all_dis) begin
            m_stable[c] = ~m_stable[c];
            m_rise[c]   = m_stable[c];
            m_fall[c]   = ~m_stable[c];
            since[c]    = 0;
         end
      end
   endtask

   task automatic check_model();
      logic [31:0] exp;
      exp = 32'({m_stable, m_rise, m_fall, |(m_rise | m_fall)});
      chk("model_hi", 32'({stable_h, rise_h, fall_h, any_h}), exp);
      chk("model_lo", 32'({stable_l, rise_l, fall_l, any_l}), exp);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_model();
   endtask

   // Called just after an edge; leaves reset released mid-cycle.
   task automatic pulse_reset(input int edges);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      repeat (edges) step();
      #2;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [CH-1:0] pins;
      int            cycles;
      logic [CH-1:0] exp_stable;
      logic [CH-1:0] exp_rise;
      logic [CH-1:0] exp_fall;
      int            exp_any;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [CH-1:0] acc_r, acc_f;
      int            any_cnt, rise_at, nrise, nfall;
      logic [CH-1:0] rise_mask;

      tbl.push_back('{4'b0001, 20, 4'b0001, 4'b0001, 4'b0000, 1});
      tbl.push_back('{4'b0101,  9, 4'b0001, 4'b0000, 4'b0000, 0});
      tbl.push_back('{4'b0000, 20, 4'b0000, 4'b0000, 4'b0001, 1});
      tbl.push_back('{4'b1111, 15, 4'b1111, 4'b1111, 4'b0000, 1});
      tbl.push_back('{4'b1111,  5, 4'b1111, 4'b0000, 4'b0000, 0});
      tbl.push_back('{4'b0110, 15, 4'b0110, 4'b0000, 4'b1001, 1});
      tbl.push_back('{4'b1001,  9, 4'b0110, 4'b0000, 4'b0000, 0});
      tbl.push_back('{4'b0110, 12, 4'b0110, 4'b0000, 4'b0000, 0});
      tbl.push_back('{4'b0000, 11, 4'b0110, 4'b0000, 4'b0000, 0});
      tbl.push_back('{4'b0000,  1, 4'b0000, 4'b0000, 4'b0110, 1});
      tbl.push_back('{4'b1000, 11, 4'b0000, 4'b0000, 4'b0000, 0});
      tbl.push_back('{4'b1000,  1, 4'b1000, 4'b1000, 4'b0000, 1});
      tbl.push_back('{4'b1000,  1, 4'b1000, 4'b0000, 4'b0000, 0});

      rst_n = 1'b1;
      pins  = '0;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("reset_async", 32'({stable_h, rise_h, fall_h, any_h, stable_l, rise_l, fall_l, any_l}), 32'd0);
      step();
      #2;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         pins    = tbl[i].pins;
         acc_r   = '0;
         acc_f   = '0;
         any_cnt = 0;
         for (int n = 0; n < tbl[i].cycles; n++) begin
            step();
            acc_r   |= rise_h;
            acc_f   |= fall_h;
            any_cnt += int'(any_h);
         end
         chk($sformatf("vec%0d_stable", i), 32'(stable_h), 32'(tbl[i].exp_stable));
         chk($sformatf("vec%0d_rise", i),   32'(acc_r),    32'(tbl[i].exp_rise));
         chk($sformatf("vec%0d_fall", i),   32'(acc_f),    32'(tbl[i].exp_fall));
         chk($sformatf("vec%0d_any", i),    32'(any_cnt),  32'(tbl[i].exp_any));
      end

      // Reset part-way through a count on ch0 while ch3 is already asserted.
      pins = 4'b1001;
      repeat (7) step();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_stable", 32'({stable_h, stable_l}), 32'd0);
      model_reset();
      step();
      step();
      #2;
      rst_n     = 1'b1;
      rise_at   = -1;
      nrise     = 0;
      nfall     = 0;
      rise_mask = '0;
      for (int e = 1; e <= 20; e++) begin
         step();
         for (int c = 0; c < CH; c++) begin
            nrise += int'(rise_h[c]) + int'(rise_l[c]);
            nfall += int'(fall_h[c]) + int'(fall_l[c]);
         end
         if (rise_h[0] && rise_at < 0) begin
            rise_at   = e;
            rise_mask = rise_h;
         end
      end
      chk("rst_rise_edge", 32'(rise_at),   32'd12);
      chk("rst_rise_mask", 32'(rise_mask), 32'b1001);
      chk("rst_rise_cnt",  32'(nrise),     32'd4);
      chk("rst_fall_cnt",  32'(nfall),     32'd0);

      // Bounce on ch1: 1,0,1,0 for three cycles each, then held high.
      rise_at = -1;
      nrise   = 0;
      nfall   = 0;
      for (int e = 1; e <= 30; e++) begin
         if (e <= 12) pins[1] = ((e - 1) / 3) % 2 == 0;
         else         pins[1] = 1'b1;
         step();
         nrise += int'(rise_h[1]);
         nfall += int'(fall_h[1]);
         if (rise_h[1] && rise_at < 0) rise_at = e;
      end
      chk("bounce_rise_edge", 32'(rise_at), 32'd24);
      chk("bounce_rise_cnt",  32'(nrise),   32'd1);
      chk("bounce_fall_cnt",  32'(nfall),   32'd0);

      // Random bursts with occasional resets, checked against the model every cycle.
      for (int b = 0; b < 200; b++) begin
         if ($urandom_range(0, 24) == 0) begin
            pulse_reset($urandom_range(1, 3));
         end
         if ($urandom_range(0, 2) == 0) pins = CH'($urandom);
         else                           pins[$urandom_range(0, CH - 1)] ^= 1'b1;
         repeat ($urandom_range(1, 14)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
